// File: rtl/frame_update_ctrl.sv
// Per-frame player-position sequencer: waits for start of vertical blanking, then runs
// capture/move/clamp/commit once every FRAME_DIV frames and signals the redraw with ref_tick.
module frame_update_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int PLAYER_W  = 16,
    parameter int PLAYER_H  = 16,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int X_INIT    = 312,
    parameter int Y_INIT    = 232
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] hc_i,
    input  logic [9:0] vc_i,
    input  logic [4:0] state_i,
    output logic       ref_tick_o,
    output logic [9:0] player_x_o,
    output logic [9:0] player_y_o,
    output logic       paused_o,
    output logic       busy_o
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [9:0]        X_MAX    = 10'(H_ACTIVE - PLAYER_W);
    localparam logic [9:0]        Y_MAX    = 10'(V_ACTIVE - PLAYER_H);
    localparam logic signed [11:0] STEP_S  = 12'(STEP);

    typedef enum logic [2:0] {IDLE, CAPTURE, MOVE, CLAMP, COMMIT} fsm_e;

    fsm_e                fsm_q;
    logic [CNT_W-1:0]    frame_cnt_q;
    logic                pause_prev_q;
    logic                paused_q;
    logic                busy_q;
    logic                ref_tick_q;
    logic [3:0]          cmd_q;
    logic signed [11:0]  nx_q, ny_q;
    logic [9:0]          player_x_q, player_y_q;

    logic                frame_start;
    logic signed [11:0]  dx, dy, nx_d, ny_d;
    logic [9:0]          cx_d, cy_d;

    assign frame_start = (vc_i == 10'(V_ACTIVE)) && (hc_i == 10'd0);

    // Opposite directions cancel on each axis independently, so diagonals still work.
    always_comb begin
        dx = '0;
        dy = '0;
        if (cmd_q[2] && !cmd_q[3]) dx = -STEP_S;
        if (cmd_q[3] && !cmd_q[2]) dx = STEP_S;
        if (cmd_q[0] && !cmd_q[1]) dy = -STEP_S;
        if (cmd_q[1] && !cmd_q[0]) dy = STEP_S;
        nx_d = $signed({2'b00, player_x_q}) + dx;
        ny_d = $signed({2'b00, player_y_q}) + dy;
    end

    always_comb begin
        cx_d = nx_q[9:0];
        cy_d = ny_q[9:0];
        if (nx_q < 0)                           cx_d = '0;
        else if (nx_q > $signed({2'b00, X_MAX})) cx_d = X_MAX;
        if (ny_q < 0)                           cy_d = '0;
        else if (ny_q > $signed({2'b00, Y_MAX})) cy_d = Y_MAX;
    end

    // Outputs are loaded on the CLAMP->COMMIT edge so ref_tick and the new position
    // are both visible for exactly the cycle the FSM spends in COMMIT.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fsm_q        <= IDLE;
            frame_cnt_q  <= '0;
            pause_prev_q <= 1'b0;
            paused_q     <= 1'b0;
            busy_q       <= 1'b0;
            ref_tick_q   <= 1'b0;
            cmd_q        <= '0;
            nx_q         <= '0;
            ny_q         <= '0;
            player_x_q   <= 10'(X_INIT);
            player_y_q   <= 10'(Y_INIT);
        end else begin
            pause_prev_q <= state_i[4];
            if (state_i[4] && !pause_prev_q)
                paused_q <= ~paused_q;
            ref_tick_q <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (frame_start) begin
                        if (frame_cnt_q == CNT_LAST) begin
                            frame_cnt_q <= '0;
                            busy_q      <= 1'b1;
                            fsm_q       <= CAPTURE;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    cmd_q <= paused_q ? 4'd0 : state_i[3:0];
                    fsm_q <= MOVE;
                end
                MOVE: begin
                    nx_q  <= nx_d;
                    ny_q  <= ny_d;
                    fsm_q <= CLAMP;
                end
                CLAMP: begin
                    player_x_q <= cx_d;
                    player_y_q <= cy_d;
                    ref_tick_q <= 1'b1;
                    fsm_q      <= COMMIT;
                end
                COMMIT: begin
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    fsm_q  <= IDLE;
                end
            endcase
        end
    end

    assign ref_tick_o = ref_tick_q;
    assign player_x_o = player_x_q;
    assign player_y_o = player_y_q;
    assign paused_o   = paused_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_frame_update_ctrl.sv
// Directed bench for frame_update_ctrl: default, edge-start and FRAME_DIV=3 instances
// share the sync/command stimulus and have independent resets.
module tb_frame_update_ctrl;

    logic       clk = 1'b0;
    logic       rst0, rst1, rst2;
    logic [9:0] hc, vc;
    logic [4:0] st;
    logic       rt0, rt1, rt2, pa0, pa1, pa2, bz0, bz1, bz2;
    logic [9:0] x0, y0, x1, y1, x2, y2;

    int passed = 0;
    int total  = 0;
    logic [5:0] m_rt0, m_rt1, m_rt2, m_bz0;

    always #20 clk = ~clk;

    frame_update_ctrl dut0 (
        .clk_i(clk), .rst_i(rst0), .hc_i(hc), .vc_i(vc), .state_i(st),
        .ref_tick_o(rt0), .player_x_o(x0), .player_y_o(y0), .paused_o(pa0), .busy_o(bz0));

    frame_update_ctrl #(.X_INIT(623), .Y_INIT(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .hc_i(hc), .vc_i(vc), .state_i(st),
        .ref_tick_o(rt1), .player_x_o(x1), .player_y_o(y1), .paused_o(pa1), .busy_o(bz1));

    frame_update_ctrl #(.FRAME_DIV(3)) dut2 (
        .clk_i(clk), .rst_i(rst2), .hc_i(hc), .vc_i(vc), .state_i(st),
        .ref_tick_o(rt2), .player_x_o(x2), .player_y_o(y2), .paused_o(pa2), .busy_o(bz2));

    typedef struct {
        logic [4:0] st;
        int         ex;
        int         ey;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // frame_start is held for one cycle; bit i of each mask is sampled after edge i+1.
    task automatic run_frame();
        vc = 10'd480;
        hc = 10'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                vc = 10'd0;
                hc = 10'd1;
            end
            m_rt0[i] = rt0;
            m_rt1[i] = rt1;
            m_rt2[i] = rt2;
            m_bz0[i] = bz0;
        end
    endtask

    initial begin
        vt[0] = '{5'b01000, 314, 232};
        vt[1] = '{5'b00100, 312, 232};
        vt[2] = '{5'b00010, 312, 234};
        vt[3] = '{5'b00001, 312, 232};
        vt[4] = '{5'b01001, 314, 230};
        vt[5] = '{5'b00110, 312, 232};
        vt[6] = '{5'b01111, 312, 232};
        vt[7] = '{5'b00000, 312, 232};
        vt[8] = '{5'b01110, 312, 234};

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        hc = 10'd1; vc = 10'd0; st = 5'b0;
        tick(); tick();
        chk("rst_x0", int'(x0), 312);
        chk("rst_y0", int'(y0), 232);
        chk("rst_ref0", int'(rt0), 0);
        chk("rst_paused0", int'(pa0), 0);
        chk("rst_busy0", int'(bz0), 0);
        chk("rst_x1", int'(x1), 623);
        chk("rst_y1", int'(y1), 1);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            st = vt[v].st;
            run_frame();
            chk($sformatf("vec%0d_ref_mask", v), int'(m_rt0), 6'b001000);
            chk($sformatf("vec%0d_x", v), int'(x0), vt[v].ex);
            chk($sformatf("vec%0d_y", v), int'(y0), vt[v].ey);
            if (v == 0) chk("busy_mask", int'(m_bz0), 6'b001111);
        end

        // Pause: held high for 3 clocks must toggle only once.
        rst0 = 1'b0; tick(); rst0 = 1'b1;
        st = 5'b10000; tick(); tick(); tick();
        st = 5'b01000; tick();
        chk("pause_set", int'(pa0), 1);
        run_frame();
        chk("paused_ref_mask", int'(m_rt0), 6'b001000);
        chk("paused_x", int'(x0), 312);
        st = 5'b11000; tick();
        st = 5'b01000; tick();
        chk("pause_clear", int'(pa0), 0);
        run_frame();
        chk("unpaused_x", int'(x0), 314);

        // Clamp at the right and top edges.
        st = 5'b0;
        rst1 = 1'b0; tick(); tick(); rst1 = 1'b1; tick();
        st = 5'b01000; run_frame();
        chk("clamp_right_x", int'(x1), 624);
        chk("clamp_right_ref", int'(m_rt1), 6'b001000);
        st = 5'b00001; run_frame();
        chk("clamp_top_y", int'(y1), 0);
        chk("clamp_top_x", int'(x1), 624);
        st = 5'b01001; run_frame();
        chk("clamp_hold_x", int'(x1), 624);
        chk("clamp_hold_y", int'(y1), 0);
        st = 5'b00101; run_frame();
        chk("clamp_leave_x", int'(x1), 622);

        // FRAME_DIV=3: only every third frame_start updates.
        st = 5'b00010;
        rst2 = 1'b0; tick(); tick(); rst2 = 1'b1; tick();
        begin
            logic [5:0] fmask;
            int nticks;
            fmask = '0;
            nticks = 0;
            for (int f = 0; f < 6; f++) begin
                run_frame();
                for (int i = 0; i < 6; i++) nticks += int'(m_rt2[i]);
                fmask[f] = (m_rt2 == 6'b001000);
            end
            chk("div3_frame_mask", int'(fmask), 6'b100100);
            chk("div3_tick_count", nticks, 2);
            chk("div3_y", int'(y2), 236);
        end

        // Reset during MOVE of the next update frame (frame 9) aborts it.
        run_frame(); run_frame();
        vc = 10'd480; hc = 10'd0;
        tick();
        vc = 10'd0; hc = 10'd1;
        tick();
        chk("div3_busy_in_move", int'(bz2), 1);
        rst2 = 1'b0;
        begin
            int late;
            late = 0;
            tick();
            rst2 = 1'b1;
            late += int'(rt2);
            for (int i = 0; i < 6; i++) begin
                tick();
                late += int'(rt2);
            end
            chk("abort_no_ref", late, 0);
        end
        chk("abort_y", int'(y2), 232);
        chk("abort_busy", int'(bz2), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
